unpack_polyvec_decompress: RTL and testbench

//   Receive side of the Kyber512 polyvec ciphertext packing (d_u = 10 bits). Accepts the

---
 rtl/unpack_polyvec_decompress.sv | 149 ++++++++++++++
 tb/tb_unpack_polyvec_decompress.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unpack_polyvec_decompress.sv
// Kyber512 polyvec u-part unpack (d_u=10): 5 bytes -> 4 coeffs, decompressed when UNPACK_POLYVEC_DECOMPRESS_EN is defined.
// First coeff valid 1 cycle after the 5th byte; coeffs stall on i_Coeff_Ready and no bytes are taken while emitting.
module unpack_polyvec_decompress #(
  parameter int KYBER_N      = 256,
  parameter int KYBER_K      = 2,
`ifdef UNPACK_POLYVEC_DECOMPRESS_EN
  parameter int KYBER_Q      = 3329,
`endif
  parameter int o_Width      = 16,
  parameter int i_Byte_Width = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Start,
  input  logic [i_Byte_Width-1:0] i_Byte,
  input  logic                    i_Byte_Valid,
  output logic                    o_Byte_Ready,
  output logic [o_Width-1:0]      o_Coeff,
  output logic                    o_Coeff_Valid,
  input  logic                    i_Coeff_Ready,
  output logic [7:0]              o_Coeff_Idx,
  output logic [0:0]              o_Poly_Idx,
  output logic                    o_Busy,
  output logic                    o_Done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  localparam logic [7:0] LAST_COEFF = 8'(KYBER_N - 1);
  localparam logic [0:0] LAST_POLY  = 1'(KYBER_K - 1);

  state_t                  state;
  logic [i_Byte_Width-1:0] grp [5];
  logic [2:0]              byte_cnt;
  logic [1:0]              lane;
  logic                    byte_acc;
  logic                    coeff_acc;
  logic                    last_coeff;
  logic [9:0]              raw_c0;
  logic [9:0]              raw_next;

  function automatic logic [o_Width-1:0] map_coeff(input logic [9:0] raw);
`ifdef UNPACK_POLYVEC_DECOMPRESS_EN
    logic [21:0] prod;
    prod = 22'(raw) * 22'(KYBER_Q) + 22'd512;
    return o_Width'(prod[21:10]);
`else
    return o_Width'(raw);
`endif
  endfunction

  assign byte_acc   = o_Byte_Ready & i_Byte_Valid;
  assign coeff_acc  = o_Coeff_Valid & i_Coeff_Ready;
  assign last_coeff = (o_Coeff_Idx == LAST_COEFF) && (o_Poly_Idx == LAST_POLY);

  // c0 only needs b0/b1, so it can be formed while b4 is still being accepted.
  always_comb begin
    raw_c0   = {grp[1][1:0], grp[0]};
    raw_next = raw_c0;
    case (lane)
      2'd0:    raw_next = {grp[2][3:0], grp[1][7:2]};
      2'd1:    raw_next = {grp[3][5:0], grp[2][7:4]};
      2'd2:    raw_next = {grp[4], grp[3][7:6]};
      default: raw_next = raw_c0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      for (int i = 0; i < 5; i++) grp[i] <= '0;
      byte_cnt      <= '0;
      lane          <= '0;
      o_Byte_Ready  <= 1'b0;
      o_Coeff       <= '0;
      o_Coeff_Valid <= 1'b0;
      o_Coeff_Idx   <= '0;
      o_Poly_Idx    <= '0;
      o_Busy        <= 1'b0;
      o_Done        <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            state        <= COLLECT;
            o_Byte_Ready <= 1'b1;
            o_Busy       <= 1'b1;
            byte_cnt     <= '0;
            lane         <= '0;
            o_Coeff_Idx  <= '0;
            o_Poly_Idx   <= '0;
          end
        end
        COLLECT: begin
          if (byte_acc) begin
            for (int i = 0; i < 5; i++)
              if (byte_cnt == 3'(i)) grp[i] <= i_Byte;
            if (byte_cnt == 3'd4) begin
              state         <= EMIT;
              byte_cnt      <= '0;
              lane          <= '0;
              o_Byte_Ready  <= 1'b0;
              o_Coeff_Valid <= 1'b1;
              o_Coeff       <= map_coeff(raw_c0);
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        EMIT: begin
          if (coeff_acc) begin
            if (lane == 2'd3) begin
              o_Coeff_Valid <= 1'b0;
              lane          <= '0;
              if (last_coeff) begin
                state       <= DONE;
                o_Busy      <= 1'b0;
                o_Done      <= 1'b1;
                o_Coeff_Idx <= '0;
                o_Poly_Idx  <= '0;
              end else begin
                state        <= COLLECT;
                o_Byte_Ready <= 1'b1;
              end
            end else begin
              lane    <= lane + 2'd1;
              o_Coeff <= map_coeff(raw_next);
            end
            // Indices track the coefficient on o_Coeff, so they step on every handshake.
            if (!last_coeff) begin
              if (o_Coeff_Idx == LAST_COEFF) begin
                o_Coeff_Idx <= '0;
                o_Poly_Idx  <= o_Poly_Idx + 1'b1;
              end else begin
                o_Coeff_Idx <= o_Coeff_Idx + 8'd1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_polyvec_decompress.sv
// Directed bench for unpack_polyvec_decompress: hand-computed groups, stall, reset abort, idle ignore, full frame.
module tb_unpack_polyvec_decompress;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_Start;
  logic [7:0]  i_Byte;
  logic        i_Byte_Valid;
  logic        o_Byte_Ready;
  logic [15:0] o_Coeff;
  logic        o_Coeff_Valid;
  logic        i_Coeff_Ready;
  logic [7:0]  o_Coeff_Idx;
  logic [0:0]  o_Poly_Idx;
  logic        o_Busy;
  logic        o_Done;

`ifdef UNPACK_POLYVEC_DECOMPRESS_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 i_Clk = ~i_Clk;

  unpack_polyvec_decompress dut (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_Start       (i_Start),
    .i_Byte        (i_Byte),
    .i_Byte_Valid  (i_Byte_Valid),
    .o_Byte_Ready  (o_Byte_Ready),
    .o_Coeff       (o_Coeff),
    .o_Coeff_Valid (o_Coeff_Valid),
    .i_Coeff_Ready (i_Coeff_Ready),
    .o_Coeff_Idx   (o_Coeff_Idx),
    .o_Poly_Idx    (o_Poly_Idx),
    .o_Busy        (o_Busy),
    .o_Done        (o_Done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int decomp(input int r);
    return DEC ? ((r * 3329 + 512) >> 10) : r;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_brdy"}, o_Byte_Ready, 0);
    chk({pfx, "_cvld"}, o_Coeff_Valid, 0);
    chk({pfx, "_coeff"}, o_Coeff, 0);
    chk({pfx, "_busy"}, o_Busy, 0);
    chk({pfx, "_done"}, o_Done, 0);
    chk({pfx, "_idx"}, o_Coeff_Idx, 0);
    chk({pfx, "_poly"}, o_Poly_Idx, 0);
  endtask

  task automatic start_frame();
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  // Called at a negedge; leaves after the 5th byte has been taken.
  task automatic send_group(input logic [39:0] g);
    for (int i = 0; i < 5; i++) begin
      int n;
      n = 0;
      while (!o_Byte_Ready && n < 100) begin
        @(negedge i_Clk);
        n++;
      end
      if (n >= 100) chk("byte_rdy_timeout", o_Byte_Ready, 1);
      i_Byte       = g[8*i +: 8];
      i_Byte_Valid = 1'b1;
      @(negedge i_Clk);
    end
    i_Byte_Valid = 1'b0;
  endtask

  task automatic recv_lane(output logic [15:0] c, output logic [7:0] idx, output logic p,
                           output logic br, output logic vld);
    int n;
    n = 0;
    while (!o_Coeff_Valid && n < 100) begin
      @(negedge i_Clk);
      n++;
    end
    vld = o_Coeff_Valid;
    c   = o_Coeff;
    idx = o_Coeff_Idx;
    p   = o_Poly_Idx;
    br  = o_Byte_Ready;
    if (vld) begin
      i_Coeff_Ready = 1'b1;
      @(negedge i_Clk);
      i_Coeff_Ready = 1'b0;
    end
  endtask

  task automatic check_group(input string name, input logic [39:0] g, input logic [39:0] raw4,
                             input logic [47:0] dec4, input int base);
    logic [15:0] c;
    logic [7:0]  idx;
    logic        p, br, vld;
    send_group(g);
    for (int l = 0; l < 4; l++) begin
      int e;
      e = DEC ? int'(dec4[12*l +: 12]) : int'(raw4[10*l +: 10]);
      recv_lane(c, idx, p, br, vld);
      chk($sformatf("%s_c%0d_vld", name, l), vld, 1);
      chk($sformatf("%s_c%0d_val", name, l), c, e);
      chk($sformatf("%s_c%0d_idx", name, l), idx, base + l);
      chk($sformatf("%s_c%0d_poly", name, l), p, 0);
      chk($sformatf("%s_c%0d_brdy", name, l), br, 0);
    end
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0]  idx;
    logic        p, br, vld;
    int          bad, ncoeff, dn, poly255, poly256;
    bit          abort;

    i_Rst_n       = 1'b0;
    i_Start       = 1'b0;
    i_Byte        = 8'h00;
    i_Byte_Valid  = 1'b0;
    i_Coeff_Ready = 1'b0;
    repeat (3) @(negedge i_Clk);
    check_reset_outputs("rst");
    i_Rst_n = 1'b1;
    @(negedge i_Clk);

    start_frame();
    chk("start_busy", o_Busy, 1);
    chk("start_brdy", o_Byte_Ready, 1);

    check_group("t1", 40'h00_0000_1234, {10'd0, 10'd0, 10'd4, 10'd564},
                {12'd0, 12'd0, 12'd13, 12'd1834}, 0);
    check_group("t2", 40'hFF_FFFF_FFFF, {4{10'd1023}}, {4{12'd3326}}, 4);
    check_group("t3", 40'h00_0000_0401, {10'd0, 10'd0, 10'd1, 10'd1},
                {12'd0, 12'd0, 12'd3, 12'd3}, 8);

    // Group 11,22,33,44,55 -> raw 529,200,67,341 / dec 1720,650,218,1109; stall on c1.
    send_group(40'h55_4433_2211);
    recv_lane(c, idx, p, br, vld);
    chk("st_c0_val", c, DEC ? 1720 : 529);
    chk("st_c0_idx", idx, 12);
    for (int n = 0; n < 100 && !o_Coeff_Valid; n++) @(negedge i_Clk);
    i_Start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("st_hold%0d_vld", s), o_Coeff_Valid, 1);
      chk($sformatf("st_hold%0d_val", s), o_Coeff, DEC ? 650 : 200);
      chk($sformatf("st_hold%0d_idx", s), o_Coeff_Idx, 13);
      chk($sformatf("st_hold%0d_brdy", s), o_Byte_Ready, 0);
      @(negedge i_Clk);
    end
    i_Start = 1'b0;
    recv_lane(c, idx, p, br, vld);
    chk("st_c1_val", c, DEC ? 650 : 200);
    chk("st_c1_idx", idx, 13);
    recv_lane(c, idx, p, br, vld);
    chk("st_c2_val", c, DEC ? 218 : 67);
    chk("st_c2_idx", idx, 14);
    recv_lane(c, idx, p, br, vld);
    chk("st_c3_val", c, DEC ? 1109 : 341);
    chk("st_c3_idx", idx, 15);
    chk("st_next_brdy", o_Byte_Ready, 1);
    chk("st_next_idx", o_Coeff_Idx, 16);

    // Abort after 3 bytes of a group.
    for (int i = 0; i < 3; i++) begin
      i_Byte       = 8'h5A;
      i_Byte_Valid = 1'b1;
      @(negedge i_Clk);
    end
    i_Byte_Valid = 1'b0;
    i_Rst_n      = 1'b0;
    @(negedge i_Clk);
    check_reset_outputs("mid_rst");
    i_Rst_n = 1'b1;

    // Bytes offered in IDLE must not be taken.
    i_Byte       = 8'hAA;
    i_Byte_Valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge i_Clk);
      chk($sformatf("idle%0d_brdy", s), o_Byte_Ready, 0);
      chk($sformatf("idle%0d_busy", s), o_Busy, 0);
    end
    i_Byte_Valid = 1'b0;
    start_frame();
    check_group("t5", 40'h00_0000_0401, {10'd0, 10'd0, 10'd1, 10'd1},
                {12'd0, 12'd0, 12'd3, 12'd3}, 0);

    // Full 640-byte frame.
    i_Rst_n = 1'b0;
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    start_frame();
    bad = 0; ncoeff = 0; poly255 = -1; poly256 = -1; abort = 1'b0;
    for (int g = 0; g < 128 && !abort; g++) begin
      logic [39:0] grp;
      for (int i = 0; i < 5; i++) grp[8*i +: 8] = 8'((g * 5 + i) * 37 + 11);
      send_group(grp);
      for (int l = 0; l < 4 && !abort; l++) begin
        int k;
        k = g * 4 + l;
        recv_lane(c, idx, p, br, vld);
        if (!vld) begin
          chk("frame_vld_timeout", vld, 1);
          abort = 1'b1;
        end else begin
          ncoeff++;
          if (c !== 16'(decomp(int'(grp[10*l +: 10])))) bad++;
          if (idx !== 8'(k % 256)) bad++;
          if (p !== 1'(k / 256)) bad++;
          if (br !== 1'b0) bad++;
          if (k == 255) poly255 = int'(p);
          if (k == 256) poly256 = int'(p);
        end
      end
    end
    chk("frame_bad", bad, 0);
    chk("frame_ncoeff", ncoeff, 512);
    chk("frame_poly255", poly255, 0);
    chk("frame_poly256", poly256, 1);
    chk("done_pulse", o_Done, 1);
    chk("done_busy", o_Busy, 0);
    chk("done_idx", o_Coeff_Idx, 0);
    chk("done_poly", o_Poly_Idx, 0);
    dn = int'(o_Done);
    for (int s = 0; s < 5; s++) begin
      @(negedge i_Clk);
      dn += int'(o_Done);
    end
    chk("done_count", dn, 1);
    chk("end_brdy", o_Byte_Ready, 0);
    chk("end_cvld", o_Coeff_Valid, 0);
    chk("end_busy", o_Busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
